// File: rtl/mul_256b_sched_pkg.sv
// rtl/mul_256b_sched_pkg.sv - widths and FSM encoding for the 256x256 limb scheduler
package mul_256b_sched_pkg;

  localparam int LIMB_W = 64;
  localparam int N_LIMB = 4;
  localparam int MUL_W  = 256;
  localparam int PROD_W = 512;
  localparam int PP_W   = 2 * LIMB_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mul_64b_wrapper.sv
// rtl/mul_64b_wrapper.sv - combinational 64x64 unsigned limb multiplier
module mul_64b_wrapper
  import mul_256b_sched_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  output logic [PP_W-1:0]   p
);

  assign p = PP_W'(a) * PP_W'(b);

endmodule

// File: rtl/mul_256b_sched.sv
// rtl/mul_256b_sched.sv - 256x256 multiply as 16 registered limb products into a 512-bit accumulator
module mul_256b_sched
  import mul_256b_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PROD_W-1:0] p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [MUL_W-1:0]  a_q, a_d;
  logic [MUL_W-1:0]  b_q, b_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PP_W-1:0]   prod_q, prod_d;
  logic [2:0]        sh_q, sh_d;
  logic              pv_q, pv_d;

  logic [LIMB_W-1:0] a_limb, b_limb;
  logic [PP_W-1:0]   mul_p;
  logic [PROD_W-1:0] pp_shifted;

  // idx[3:2] walks the a limbs, idx[1:0] the b limbs
  assign a_limb = a_q[{idx_q[3:2], 6'd0} +: LIMB_W];
  assign b_limb = b_q[{idx_q[1:0], 6'd0} +: LIMB_W];

  mul_64b_wrapper U_mul_64 (
    .a (a_limb),
    .b (b_limb),
    .p (mul_p)
  );

  assign pp_shifted = PROD_W'(prod_q) << {sh_q, 6'd0};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    sh_d    = sh_q;
    pv_d    = 1'b0;
    // a*b < 2^512, so dropping the carry out of bit 511 is exact
    acc_d   = pv_q ? (acc_q + pp_shifted) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          idx_d   = 4'd0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        prod_d = mul_p;
        sh_d   = {1'b0, idx_q[3:2]} + {1'b0, idx_q[1:0]};
        pv_d   = 1'b1;
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      sh_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      sh_q    <= sh_d;
      pv_q    <= pv_d;
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign p         = acc_q;

endmodule

// File: tb/tb_mul_256b_sched.sv
// tb/tb_mul_256b_sched.sv - randomized self-checking bench for mul_256b_sched
module tb_mul_256b_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] a = '0, b = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] p;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  time last_accept = 0;
  bit  have_accept = 0;

  mul_256b_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] xx, yy;
    xx = {256'd0, x};
    yy = {256'd0, y};
    return xx * yy;
  endfunction

  // one full operation; bp=1 toggles out_ready randomly while the result waits
  task automatic run_op(input string tag, input logic [255:0] ta, input logic [255:0] tb_op,
                        input logic [511:0] exp, input bit bp, input bit chk_gap);
    int     w, lat;
    bit     busy_ok, stable_ok, took;
    time    gap;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    expect_eq({tag, "_rdy_timeout"}, 512'(w < 100), 512'd1);
    a = ta; b = tb_op; in_valid = 1'b1;
    @(posedge clk);
    if (chk_gap && have_accept) begin
      gap = ($time - last_accept) / 10;
      expect_eq({tag, "_gap_ge19"}, 512'(gap >= 19), 512'd1);
    end
    last_accept = $time;
    have_accept = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = rand256(); b = rand256();
    lat = 0; busy_ok = 1;
    while (!out_valid && lat < 100) begin
      if (!busy) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    expect_eq({tag, "_latency"}, 512'(lat), 512'd17);
    expect_eq({tag, "_busy"}, 512'(busy_ok), 512'd1);
    expect_eq({tag, "_p"}, p, exp);
    stable_ok = 1; took = 0; w = 0;
    while (!took && w < 100) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      took = out_ready;
      @(posedge clk);
      @(negedge clk);
      if (!took && (p !== exp || !out_valid || in_ready)) stable_ok = 0;
      w++;
    end
    out_ready = 1'b0;
    expect_eq({tag, "_stable"}, 512'(stable_ok), 512'd1);
    expect_eq({tag, "_consumed"}, 512'(out_valid), 512'd0);
  endtask

  initial begin
    logic [511:0] e;
    logic [255:0] ra, rb, ones;
    int errs_before;

    #1;
    expect_eq("rst_out_valid", 512'(out_valid), 512'd0);
    expect_eq("rst_p", p, 512'd0);
    expect_eq("rst_busy", 512'(busy), 512'd0);
    expect_eq("rst_in_ready", 512'(in_ready), 512'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_eq("post_rst_in_ready", 512'(in_ready), 512'd1);

    run_op("one", 256'd1, 256'd1, 512'd1, 1'b0, 1'b0);

    ones = '1;
    e = 512'd0 - (512'd1 << 257) + 512'd1;
    run_op("allones", ones, ones, e, 1'b0, 1'b0);

    run_op("zero", 256'd0, rand256(), 512'd0, 1'b0, 1'b0);
    run_op("pow192", 256'd1 << 192, 256'd1 << 192, 512'd1 << 384, 1'b0, 1'b0);

    // backpressure with an ignored in_valid pulse
    ra = rand256(); rb = rand256(); e = ref_mul(ra, rb);
    @(negedge clk);
    a = ra; b = rb; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    expect_eq("bp_valid_rise", 512'(out_valid), 512'd1);
    errs_before = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = rand256(); b = rand256(); in_valid = 1'b1; end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
      if (p !== e || !out_valid || in_ready || !busy) errs_before++;
    end
    expect_eq("bp_hold", 512'(errs_before), 512'd0);
    expect_eq("bp_p", p, e);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    expect_eq("bp_released", 512'(out_valid), 512'd0);
    expect_eq("bp_in_ready", 512'(in_ready), 512'd1);
    repeat (3) @(negedge clk);
    expect_eq("bp_no_ghost_op", 512'(busy), 512'd0);

    // reset in the middle of MUL, at idx=7
    @(negedge clk);
    a = rand256(); b = rand256(); in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("midrst_out_valid", 512'(out_valid), 512'd0);
    expect_eq("midrst_p", p, 512'd0);
    expect_eq("midrst_busy", 512'(busy), 512'd0);
    expect_eq("midrst_in_ready", 512'(in_ready), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 256'd3, 256'd5, 512'd15, 1'b0, 1'b0);

    have_accept = 0;
    for (int k = 0; k < 1000; k++) begin
      ra = rand256(); rb = rand256();
      case (k % 8)
        1: ra = ra >> $urandom_range(0, 255);
        2: rb = '1;
        3: ra[63:0] = '0;
        default: ;
      endcase
      run_op("rand", ra, rb, ref_mul(ra, rb), 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_256b_sched.md
# mul_256b_sched

- Schedules one 256×256-bit unsigned multiplication as 16 sequential 64×64-bit limb products through one `mul_64b_wrapper` instance.
- Accumulates the shifted 128-bit partial products into a 512-bit result.
- Sits directly upstream of the 64-bit multiplier and feeds the SM2 modular-reduction stage; one operation is in flight at a time.

## Interface
Parameters: none. Widths are fixed by `sm2_cfg.v` constants.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  256  multiplicand; limb k = bits 64k+63:64k.
- `b`  in  256  multiplier; same limb order.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block accepts operands; high only in IDLE.
- `p`  out  512  product a·b; valid while `out_valid`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `busy`  out  1  high in MUL, DRAIN and DONE.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`: latch a/b, clear acc, idx←0, go to MUL.
  - MUL: drive the multiplier with `a_limb[idx[3:2]]`, `b_limb[idx[1:0]]`. Each edge: prod_q←multiplier p, sh_q←idx[3:2]+idx[1:0], pv_q←1, idx←idx+1. After idx=15 is issued, go to DRAIN.
  - DRAIN: one cycle; accumulates the final product. Go to DONE.
  - DONE: `out_valid`=1, `p`=acc. On `out_ready`: go to IDLE, `out_valid`←0.
- Accumulation: each edge with pv_q=1, acc←acc + (prod_q << 64·sh_q). sh_q ranges 0..6.
  - 512-bit add, no carry out of bit 511. Guaranteed because a·b < 2^512; the bench asserts it.
- pv_q is cleared in IDLE and DONE.
- `in_valid` outside IDLE is ignored. Operands are taken only at the handshake edge; later changes to `a`/`b` have no effect.
- `p` and `out_valid` stay stable in DONE until `out_ready`. No output changes under backpressure.
- Reset values, forced immediately on `rst_n` low at any time including mid-operation:
  - state=IDLE, idx=0, acc=0, pv_q=0.
  - `out_valid`=0, `p`=0, `busy`=0.
  - `in_ready`=0 while `rst_n` low; 1 from the first cycle after release.
- No partial result survives a reset.

## Timing
- Multiplier path is combinational inside the wrapper; it is registered once here (prod_q).
- Accepting edge = E0. MUL occupies cycles E0..E16, products registered at E1..E16.
- Accumulations occur at E2..E17. E17 falls in DRAIN.
- `out_valid` rises after E17: latency 17 cycles.
- With `out_ready` held high: result consumed at E18, `in_ready` high after E18, next accept at E19 at the earliest. Minimum issue interval is 19 cycles.
- `out_ready` low for N cycles extends DONE by N cycles.
- `in_ready` is combinational from state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Constants go in `sm2_cfg.v`: `LIMB_W`=64, `N_LIMB`=4, `MUL_W`=256, `PROD_W`=512.
- Encode the state constants in the same include.
- One sub-module: `mul_64b_wrapper` (U_mul_64), unmodified. `DESIGN_FPGA`/`DESIGN_SIM` selection stays inside it.
- The scheduler FSM, limb mux, product register and accumulator live in this module.

## Test plan
1. a=1, b=1 → `p`=1; `out_valid` first high exactly 17 cycles after the accept edge; `busy` high throughout.
2. a=b=2^256−1 → `p`=2^512−2^257+1. Exercises the full carry chain and the no-carry-out assertion.
3. a=0, b=0xDEADBEEF…(random) → `p`=0. Then a=2^192, b=2^192 → `p`=2^384 (only limb pair 3,3 nonzero, sh=6).
4. Backpressure: `out_ready` low 10 cycles in DONE → `p` and `out_valid` stable and `in_ready`=0. A second `in_valid` pulse is ignored. Release → exactly one result consumed.
5. Assert `rst_n` low while idx=7 → all outputs at reset values at once. After release, a=3, b=5 → `p`=15 with 17-cycle latency.
6. 1000 random operand pairs back-to-back with `out_ready` randomly toggled → every `p` matches the reference model. Issue interval never below 19 cycles.
